axi4l_req_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ simple register-access requesters (req/done command interface). It grants one requester at a time, latches its command, and runs a single AXI4-Lite write (AW+W→B) or read (AR→R) transaction. It then returns the response to the granted requester. It sits in front of the AXI4-Lite register fabric, so several on-chip agents (CPU bridge, debug UART, DMA config) can reach the same register slaves.

---
 rtl/axi4l_req_arbiter_pkg.sv | 28 ++
 rtl/axi4l_req_arbiter_rr_pick.sv | 41 ++++
 rtl/axi4l_req_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_axi4l_req_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_req_arbiter_pkg.sv
// Shared types for the AXI4-Lite request arbiter: response codes and FSM states.
package axi4l_req_arbiter_pkg;

    typedef logic [1:0] axi4l_resp_t;

    localparam axi4l_resp_t RESP_OKAY   = 2'b00;
    localparam axi4l_resp_t RESP_EXOKAY = 2'b01;
    localparam axi4l_resp_t RESP_SLVERR = 2'b10;
    localparam axi4l_resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_WR,
        ARB_WR_RESP,
        ARB_RD_ADDR,
        ARB_RD_RESP,
        ARB_DONE
    } axi4l_arb_state_t;

    function automatic logic resp_is_ok(input axi4l_resp_t resp);
        return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
    endfunction

    function automatic logic resp_is_error(input axi4l_resp_t resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi4l_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// modulo NUM_REQ; returns both the one-hot grant and its binary index.
module axi4l_req_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand [NUM_REQ];

    // cand[k] is the requester visited k steps after ptr.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                            ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                            : IDX_W'(sum);
        end
    endgenerate

    // Walk from the farthest candidate back so the nearest one wins.
    always_comb begin
        idx    = '0;
        onehot = '0;
        valid  = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx = cand[k];
            end
        end
        onehot[idx] = valid;
    end

endmodule

// File: rtl/axi4l_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among NUM_REQ
// req/done requesters; one single-beat write or read in flight at a time.
module axi4l_req_arbiter
    import axi4l_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             axi4l_aclk,
    input  logic                             axi4l_arstn,

    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               done,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,

    output logic [ADDR_WIDTH-1:0]            m_awaddr,
    output logic                             m_awvalid,
    input  logic                             m_awready,
    output logic [DATA_WIDTH-1:0]            m_wdata,
    output logic [DATA_WIDTH/8-1:0]          m_wstrb,
    output logic                             m_wvalid,
    input  logic                             m_wready,
    input  logic [1:0]                       m_bresp,
    input  logic                             m_bvalid,
    output logic                             m_bready,
    output logic [ADDR_WIDTH-1:0]            m_araddr,
    output logic                             m_arvalid,
    input  logic                             m_arready,
    input  logic [DATA_WIDTH-1:0]            m_rdata,
    input  logic [1:0]                       m_rresp,
    input  logic                             m_rvalid,
    output logic                             m_rready
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;

    axi4l_arb_state_t state_reg, state_next;

    logic [IDX_W-1:0]      ptr_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [IDX_W-1:0]      ptr_inc;
    logic [NUM_REQ-1:0]    gnt_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]     wstrb_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    axi4l_resp_t           rsp_resp_reg;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;

    logic aw_hs, w_hs, b_hs, r_hs;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]     wstrb_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wstrb_arr[gi] = req_wstrb[gi*STRB_W +: STRB_W];
        end
    endgenerate

    axi4l_req_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid  & m_wready;
    assign b_hs  = m_bready  & m_bvalid;
    assign r_hs  = m_rready  & m_rvalid;

    assign ptr_inc = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;

    // State register
    always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
        if (!axi4l_arstn) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = req_we[pick_idx] ? ARB_WR : ARB_RD_ADDR;
                end
            end
            ARB_WR: begin
                // AW and W complete independently, possibly in different cycles.
                if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                    state_next = ARB_WR_RESP;
                end
            end
            ARB_WR_RESP: begin
                if (m_bvalid) begin
                    state_next = ARB_DONE;
                end
            end
            ARB_RD_ADDR: begin
                if (m_arready) begin
                    state_next = ARB_RD_RESP;
                end
            end
            ARB_RD_RESP: begin
                if (m_rvalid) begin
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Output decode; all channel controls come straight from registered state.
    always_comb begin
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        done      = '0;
        case (state_reg)
            ARB_WR: begin
                m_awvalid = ~aw_done_reg;
                m_wvalid  = ~w_done_reg;
            end
            ARB_WR_RESP: m_bready  = 1'b1;
            ARB_RD_ADDR: m_arvalid = 1'b1;
            ARB_RD_RESP: m_rready  = 1'b1;
            ARB_DONE:    done      = gnt_reg;
            default: begin
                m_awvalid = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_reg;
    assign m_awaddr  = addr_reg;
    assign m_araddr  = addr_reg;
    assign m_wdata   = wdata_reg;
    assign m_wstrb   = wstrb_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_resp  = rsp_resp_reg;

    // Grant and round-robin pointer
    always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
        if (!axi4l_arstn) begin
            gnt_reg <= '0;
            idx_reg <= '0;
            ptr_reg <= '0;
        end else if (state_reg == ARB_IDLE && pick_valid) begin
            gnt_reg <= pick_onehot;
            idx_reg <= pick_idx;
        end else if (state_reg == ARB_DONE) begin
            gnt_reg <= '0;
            ptr_reg <= ptr_inc;
        end
    end

    // Command latch: requester inputs are ignored for the rest of the transaction.
    always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
        if (!axi4l_arstn) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else if (state_reg == ARB_IDLE && pick_valid) begin
            addr_reg  <= addr_arr[pick_idx];
            wdata_reg <= wdata_arr[pick_idx];
            wstrb_reg <= wstrb_arr[pick_idx];
        end
    end

    // Per-channel completion flags for the write address/data pair
    always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
        if (!axi4l_arstn) begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else if (state_reg == ARB_WR) begin
            if (aw_hs) begin
                aw_done_reg <= 1'b1;
            end
            if (w_hs) begin
                w_done_reg <= 1'b1;
            end
        end else begin
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end
    end

    // Response capture; held until the next response overwrites it.
    always_ff @(posedge axi4l_aclk or negedge axi4l_arstn) begin
        if (!axi4l_arstn) begin
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= RESP_OKAY;
        end else if (state_reg == ARB_WR_RESP && b_hs) begin
            rsp_rdata_reg <= '0;
            rsp_resp_reg  <= axi4l_resp_t'(m_bresp);
        end else if (state_reg == ARB_RD_RESP && r_hs) begin
            rsp_rdata_reg <= m_rdata;
            rsp_resp_reg  <= axi4l_resp_t'(m_rresp);
        end
    end

endmodule

// File: tb/tb_axi4l_req_arbiter.sv
// Directed bench for axi4l_req_arbiter: scripted requesters, a delay-programmable
// AXI4-Lite slave, and a scoreboard checked on every done pulse.
module tb_axi4l_req_arbiter;
    import axi4l_req_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    logic [NR-1:0]    req = '0;
    logic [NR-1:0]    req_we = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR*SW-1:0] req_wstrb = '0;
    logic [NR-1:0]    gnt, done;
    logic [DW-1:0]    rsp_rdata;
    logic [1:0]       rsp_resp;

    logic [AW-1:0] m_awaddr, m_araddr;
    logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
    logic          m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
    logic [DW-1:0] m_rdata = '0;

    axi4l_req_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .axi4l_aclk  (clk),
        .axi4l_arstn (arstn),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .gnt         (gnt),
        .done        (done),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .m_awaddr    (m_awaddr),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .m_araddr    (m_araddr),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_rdata     (m_rdata),
        .m_rresp     (m_rresp),
        .m_rvalid    (m_rvalid),
        .m_rready    (m_rready)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Slave configuration
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
    logic [31:0] r_data_cfg = '0;
    bit          r_from_addr = 1'b0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    // Handshake capture at the active edge
    int          cyc = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, b_rise_cyc = 0;
    int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0;
    logic        prev_bready = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_awvalid && m_awready) begin
            cap_awaddr <= m_awaddr;
            aw_hs_cyc  <= cyc;
        end
        if (m_wvalid && m_wready) begin
            cap_wdata <= m_wdata;
            cap_wstrb <= m_wstrb;
            w_hs_cyc  <= cyc;
        end
        if (m_arvalid && m_arready) begin
            cap_araddr <= m_araddr;
        end
        if (m_bready && !prev_bready) begin
            b_rise_cyc <= cyc;
        end
        prev_bready <= m_bready;
        if (m_awvalid) aw_vcyc <= aw_vcyc + 1;
        if (m_wvalid)  w_vcyc  <= w_vcyc + 1;
        if (m_arvalid) ar_vcyc <= ar_vcyc + 1;
    end

    // Slave responses, set up on the falling edge for the next rising edge
    always @(negedge clk) begin
        if (m_awvalid) begin m_awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin m_awready = 1'b0; aw_cnt = 0; end
        if (m_wvalid) begin m_wready = (w_cnt >= w_dly); w_cnt++; end
        else begin m_wready = 1'b0; w_cnt = 0; end
        if (m_arvalid) begin m_arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin m_arready = 1'b0; ar_cnt = 0; end
        if (m_bready) begin
            m_bvalid = (b_cnt >= b_dly);
            m_bresp  = b_resp_cfg;
            b_cnt++;
        end else begin
            m_bvalid = 1'b0;
            b_cnt = 0;
        end
        if (m_rready) begin
            m_rvalid = (r_cnt >= r_dly);
            m_rresp  = r_resp_cfg;
            m_rdata  = r_from_addr ? (cap_araddr ^ 32'hA5A5_0000) : r_data_cfg;
            r_cnt++;
        end else begin
            m_rvalid = 1'b0;
            r_cnt = 0;
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [NR-1:0] done;
        logic [31:0]   rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [NR-1:0] glog[$];
    logic [NR-1:0] prev_done = '0;
    logic [NR-1:0] prev_gnt = '0;
    int            done_count = 0;

    always @(negedge clk) begin
        if (done != '0) begin
            chk("done_single_cycle", 64'(prev_done), 64'd0);
            if (sb.size() == 0) begin
                chk("done_unexpected", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_idx", 64'(done), 64'(mon_e.done));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_resp", 64'(rsp_resp), 64'(mon_e.resp));
            end
            done_count++;
            $display("txn done=%b rdata=0x%08h resp=%0d count=%0d", done, rsp_rdata, rsp_resp, done_count);
        end
        prev_done = done;
        if (gnt != '0 && gnt != prev_gnt) begin
            glog.push_back(gnt);
        end
        prev_gnt = gnt;
    end

    task automatic push_exp(input int i, input logic [31:0] rd, input logic [1:0] rs);
        exp_t x;
        x.done    = '0;
        x.done[i] = 1'b1;
        x.rdata   = rd;
        x.resp    = rs;
        sb.push_back(x);
    endtask

    task automatic drive_req(input int i, input bit we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] ws);
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = wd;
        req_wstrb[i*SW +: SW] = ws;
        req[i]                = 1'b1;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_count < target && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_done_reached"}, 64'(done_count >= target), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw0, w0, ar0, g0, n;
        logic [NR-1:0] exp_g;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_wvalid), 64'd0);
        chk("rst_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_bready", 64'(m_bready), 64'd0);
        chk("rst_rready", 64'(m_rready), 64'd0);
        chk("rst_rsp_resp", 64'(rsp_resp), 64'd0);
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        #1;

        // Single write from requester 0
        push_exp(0, 32'h0, RESP_OKAY);
        drive_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        #1;
        chk("t1_gnt_latency", 64'(gnt), 64'b01);
        chk("t1_awvalid", 64'(m_awvalid), 64'd1);
        chk("t1_wvalid", 64'(m_wvalid), 64'd1);
        wait_done(1, "t1");
        req[0] = 1'b0;
        chk("t1_awaddr", 64'(cap_awaddr), 64'h10);
        chk("t1_wdata", 64'(cap_wdata), 64'hDEAD_BEEF);
        chk("t1_wstrb", 64'(cap_wstrb), 64'hF);

        // Read from requester 1 with a slow slave
        ar_dly = 2;
        r_dly = 4;
        r_data_cfg = 32'h1234_5678;
        ar0 = ar_vcyc;
        push_exp(1, 32'h1234_5678, RESP_OKAY);
        drive_req(1, 1'b0, 32'h0000_0004, 32'h0, 4'h0);
        wait_done(2, "t2");
        req[1] = 1'b0;
        chk("t2_arvalid_cycles", 64'(ar_vcyc - ar0), 64'd3);
        chk("t2_araddr", 64'(cap_araddr), 64'h4);
        ar_dly = 0;
        r_dly = 0;

        // Write data accepted well before write address
        aw_dly = 4;
        w_dly = 0;
        aw0 = aw_vcyc;
        w0 = w_vcyc;
        push_exp(0, 32'h0, RESP_OKAY);
        drive_req(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3);
        wait_done(3, "t3");
        req[0] = 1'b0;
        chk("t3_awvalid_cycles", 64'(aw_vcyc - aw0), 64'd5);
        chk("t3_wvalid_cycles", 64'(w_vcyc - w0), 64'd1);
        chk("t3_w_before_aw", 64'(w_hs_cyc < aw_hs_cyc), 64'd1);
        chk("t3_bready_after_aw", 64'(b_rise_cyc > aw_hs_cyc), 64'd1);
        chk("t3_awaddr", 64'(cap_awaddr), 64'h20);
        chk("t3_wdata", 64'(cap_wdata), 64'hCAFE_F00D);
        chk("t3_wstrb", 64'(cap_wstrb), 64'h3);
        aw_dly = 0;

        // Decode error on read passes straight through
        r_resp_cfg = RESP_DECERR;
        r_data_cfg = 32'h0BAD_0BAD;
        push_exp(1, 32'h0BAD_0BAD, RESP_DECERR);
        drive_req(1, 1'b0, 32'hFFFF_0000, 32'h0, 4'h0);
        wait_done(4, "t4");
        req[1] = 1'b0;
        r_resp_cfg = RESP_OKAY;

        // Both requesters held for six transactions: strict alternation from 0
        r_from_addr = 1'b1;
        g0 = glog.size();
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_exp(0, 32'hA5A5_0100, RESP_OKAY);
            else            push_exp(1, 32'hA5A5_0104, RESP_OKAY);
        end
        drive_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        drive_req(1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
        wait_done(10, "t5");
        req = '0;
        r_from_addr = 1'b0;
        chk("t5_grant_count", 64'(glog.size() - g0), 64'd6);
        n = glog.size() - g0;
        for (int k = 0; k < 6 && k < n; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("t5_grant_%0d", k), 64'(glog[g0 + k]), 64'(exp_g));
        end

        // Requester 0 goes last so the pointer moves to 1 before the reset test
        push_exp(0, 32'h0, RESP_OKAY);
        drive_req(0, 1'b1, 32'h0000_0030, 32'h3333_3333, 4'hF);
        wait_done(11, "t6");
        req[0] = 1'b0;

        // Reset in the middle of a write from requester 1
        aw_dly = 30;
        w_dly = 30;
        drive_req(1, 1'b1, 32'h0000_0040, 32'h4444_4444, 4'hF);
        n = 0;
        while (!m_awvalid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t7_awvalid_seen", 64'(m_awvalid), 64'd1);
        @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        chk("t7_awvalid_async", 64'(m_awvalid), 64'd0);
        chk("t7_wvalid_async", 64'(m_wvalid), 64'd0);
        chk("t7_gnt_async", 64'(gnt), 64'd0);
        chk("t7_done_async", 64'(done), 64'd0);
        req[1] = 1'b0;
        aw_dly = 0;
        w_dly = 0;
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        #1;
        chk("t7_no_done_in_reset", 64'(done_count), 64'd11);
        push_exp(0, 32'h0, RESP_OKAY);
        push_exp(1, 32'h0, RESP_OKAY);
        drive_req(0, 1'b1, 32'h0000_0050, 32'h5555_5555, 4'hF);
        drive_req(1, 1'b1, 32'h0000_0060, 32'h6666_6666, 4'hF);
        @(negedge clk);
        #1;
        chk("t7_ptr_reset_gnt", 64'(gnt), 64'b01);
        wait_done(12, "t7a");
        req[0] = 1'b0;
        chk("t7_awaddr_first", 64'(cap_awaddr), 64'h50);
        wait_done(13, "t7b");
        req[1] = 1'b0;
        chk("t7_awaddr_second", 64'(cap_awaddr), 64'h60);
        chk("t7_wdata_second", 64'(cap_wdata), 64'h6666_6666);

        repeat (3) @(negedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_done_count", 64'(done_count), 64'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
